// File: rtl/cpu_clk_pkg.sv
// rtl/cpu_clk_pkg.sv - shared types and constants for the CPU clock conditioner
package cpu_clk_pkg;

  typedef enum logic [2:0] {
    RST_RUN,
    RUN,
    STEP_IDLE,
    STEP_HI,
    STEP_LO
  } clk_state_t;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - pushbutton synchroniser, debouncer and press-pulse generator
module key_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic CLOCK,
  input  logic Reset,
  input  logic raw_n,
  output logic stable,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser; idle level of an active-low key is 1
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive samples disagree with the current one
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // One-cycle pulse on the accepted 1->0 transition (key pressed)
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      stable_d <= 1'b1;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable_d & ~stable;
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - CPU clock/reset conditioner (run/step, reset stretch, cycle count; CLKCTRL_BREAK_EN adds PC breakpoint)
module cpu_clock_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_LOG2   = 2,
  parameter int DEB_CYCLES = 50000,
  parameter int RST_EDGES  = 2
) (
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic        KeyStep_n,
  input  logic        KeyMode_n,
  input  logic [31:0] PC,
  input  logic [31:0] BreakAddr,
  output logic        ClockDIV,
  output logic        CpuReset,
  output logic        Mode,
  output logic [31:0] CycleCount
);

  localparam int H   = 1 << (DIV_LOG2 - 1);
  localparam int CW  = (DIV_LOG2 > 1) ? (DIV_LOG2 - 1) : 1;
  localparam int RCW = (RST_EDGES > 0) ? $clog2(RST_EDGES + 1) : 1;

  clk_state_t     state;
  logic [CW-1:0]  ctr;
  logic [RCW-1:0] rst_cnt;
  logic           mode_pend;
  logic           ctr_last;
  logic           step_press;
  logic           mode_press;
  logic           step_stable;
  logic           mode_stable;
  logic           brk_fire;

  assign ctr_last = (ctr == CW'(H - 1));

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .CLOCK  (CLOCK),
    .Reset  (Reset),
    .raw_n  (KeyStep_n),
    .stable (step_stable),
    .press  (step_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .CLOCK  (CLOCK),
    .Reset  (Reset),
    .raw_n  (KeyMode_n),
    .stable (mode_stable),
    .press  (mode_press)
  );

`ifdef CLKCTRL_BREAK_EN
  logic brk_inert;

  // A breakpoint fires on a falling ClockDIV edge in RUN, at most once per visit of PC to BreakAddr
  assign brk_fire = (state == RUN) && ClockDIV && ctr_last && !brk_inert && (PC == BreakAddr);

  // Keep a fired breakpoint quiet until the PC moves off the address
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      brk_inert <= 1'b0;
    end else if (brk_fire) begin
      brk_inert <= 1'b1;
    end else if (PC != BreakAddr) begin
      brk_inert <= 1'b0;
    end
  end
`else
  logic unused_brk;

  assign brk_fire   = 1'b0;
  assign unused_brk = ^{PC, BreakAddr};
`endif

  logic unused_stable;
  assign unused_stable = step_stable ^ mode_stable;

  // Phase counter, clock FSM, reset stretcher and executed-cycle counter
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state      <= RST_RUN;
      ClockDIV   <= 1'b0;
      CpuReset   <= 1'b1;
      Mode       <= MODE_RUN;
      CycleCount <= '0;
      ctr        <= '0;
      rst_cnt    <= '0;
      mode_pend  <= 1'b0;
    end else begin
      // A mode request is remembered until a state that can apply it consumes it
      if (mode_press || brk_fire) mode_pend <= 1'b1;

      case (state)
        RST_RUN: begin
          if (ctr_last) begin
            ctr      <= '0;
            ClockDIV <= ~ClockDIV;
            if (!ClockDIV) begin
              if (rst_cnt != RCW'(RST_EDGES)) rst_cnt <= rst_cnt + RCW'(1);
            end else if (rst_cnt == RCW'(RST_EDGES)) begin
              CpuReset <= 1'b0;
              state    <= (Mode == MODE_STEP) ? STEP_IDLE : RUN;
            end
          end else begin
            ctr <= ctr + CW'(1);
          end
        end

        RUN: begin
          if (ctr_last) begin
            ctr <= '0;
            // Switch only at the end of a low phase so no shortened pulse escapes
            if (!ClockDIV && mode_pend) begin
              Mode      <= MODE_STEP;
              mode_pend <= 1'b0;
              state     <= STEP_IDLE;
            end else begin
              ClockDIV <= ~ClockDIV;
              if (!ClockDIV && !CpuReset) CycleCount <= CycleCount + 32'd1;
            end
          end else begin
            ctr <= ctr + CW'(1);
          end
        end

        STEP_IDLE: begin
          if (step_press) begin
            ClockDIV   <= 1'b1;
            ctr        <= '0;
            state      <= STEP_HI;
            CycleCount <= CycleCount + 32'd1;
          end else if (mode_pend || mode_press) begin
            Mode      <= MODE_RUN;
            mode_pend <= 1'b0;
            ctr       <= '0;
            state     <= RUN;
          end
        end

        STEP_HI: begin
          if (ctr_last) begin
            ClockDIV <= 1'b0;
            ctr      <= '0;
            state    <= STEP_LO;
          end else begin
            ctr <= ctr + CW'(1);
          end
        end

        STEP_LO: begin
          if (ctr_last) begin
            ctr   <= '0;
            state <= STEP_IDLE;
          end else begin
            ctr <= ctr + CW'(1);
          end
        end

        default: begin
          state    <= RST_RUN;
          ClockDIV <= 1'b0;
          CpuReset <= 1'b1;
        end
      endcase
    end
  end

endmodule
